serial_adder: RTL
=================

# serial_adder

Bit-serial adder that streams two WIDTH-bit operands LSB-first through a single full-adder cell, holding the ripple carry in a flip-flop between cycles. It sits around the combinational full-adder stage: it serializes operands into the cell's a/b/cin inputs, registers the cell's carry back into cin, and collects sum bits into a result register. It trades WIDTH+1 cycles of latency for one adder cell, and is driven by a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  initial carry-in; captured on accepted start.
- sub  input  1  subtract select; captured on accepted start. Present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while an operation is in progress (SHIFT and DONE).
- done  output  1  one-cycle pulse; sum/carry valid from this cycle.
- sum  output  WIDTH  registered result.
- carry  output  1  registered carry-out of the MSB.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: capture a, b into shift registers and cin into the carry flop, clear the bit counter, go to SHIFT. With start=0, stay in IDLE.
- SHIFT, each cycle:
  - Full-adder cell evaluates a_sr[0], b_sr[0] and carry flop.
  - Sum bit shifts into the MSB of the internal sum shift register.
  - Cell carry loads the carry flop.
  - a_sr and b_sr shift right.
  - Counter increments.
- Leave SHIFT after exactly WIDTH bit-cycles, i.e. when the counter reaches WIDTH-1.
- On the SHIFT->DONE transition, load the internal sum register into sum and the final carry into carry.
- DONE: done=1 for one cycle, then unconditionally go to IDLE.
- Counter width is $clog2(WIDTH); no wrap occurs before exit.
- Arithmetic: {carry,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- sum and carry hold their value from the last DONE until the next DONE. Intermediate shift state is never visible on the outputs.
- start while busy (SHIFT or DONE) is ignored, not queued. Operand changes after capture have no effect.

## Timing
- Reset (rst_n=0 at a clock edge) gives state IDLE, busy=0, done=0, sum=0, carry=0, and clears all internal registers.
- Reset has priority over start and aborts an operation mid-flight. No done is issued and outputs read 0 on the next cycle.
- Start accepted at edge k:
  - busy=1 from cycle k+1.
  - SHIFT occupies cycles k+1..k+WIDTH.
  - done=1 and the new sum/carry appear in cycle k+WIDTH+1.
  - busy=0 from cycle k+WIDTH+2.
- Start-to-done latency is WIDTH+1 cycles. The next start is accepted earliest in the cycle after done (throughput one result per WIDTH+2 cycles).
- A start asserted during the done cycle is ignored.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - With sub=1 at capture, b is inverted into b_sr and the carry flop is loaded with 1; cin is ignored.
  - Result is {carry,sum} = a + ~b + 1, so carry=1 means no borrow (a>=b unsigned).
  - With sub=0, behaviour equals the plain adder.
- SERIAL_ADDER_SUB_EN undefined: no sub port; add only.

## Test plan
- WIDTH=8, a=0xFF, b=0x01, cin=0, start pulse at cycle 0 -> done at cycle 9 with sum=0x00, carry=1; busy high cycles 1..9.
- a=0x5A, b=0x33, cin=1 -> sum=0x8E, carry=0. Then start=1 held through the operation -> second start accepted only in the cycle after done.
- Operation in flight, rst_n=0 at cycle 4 -> no done; from cycle 5 busy=0, sum=0x00, carry=0. Next start completes normally.
- Previous result 0x8E held; new start with a=0x00, b=0x00, cin=0 -> sum stays 0x8E until the done cycle, then 0x00.
- With SERIAL_ADDER_SUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, carry=1; a=0x01, b=0x02, sub=1, cin=1 -> sum=0xFF, carry=0.
- WIDTH=4, exhaustive: all a, b, cin (and sub when enabled) checked against the arithmetic model, with done latency exactly 5 cycles each.

Source files
------------

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for serial_adder.
// Handshake: the master raises start with a, b, cin (and sub when
// SERIAL_ADDER_SUB_EN is defined) stable; the slave captures them on the first
// clock edge where it is idle and start is high. busy stays high until the
// result cycle has passed; done pulses for exactly one cycle, and sum/carry
// are valid from that cycle until the next done.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, carry);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, carry);
`else
  modport master (output start, a, b, cin, input busy, done, sum, carry);
  modport slave  (input start, a, b, cin, output busy, done, sum, carry);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, operands streamed LSB-first, ripple
// carry held in a flop between bit-cycles. Latency start->done is WIDTH+1.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a subtract select (a - b
// as a + ~b + 1; carry=1 means no borrow).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_if.slave       bus_if,
  output logic [1:0]          state_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  // Capture-time operand conditioning: subtract inverts b and forces carry-in.
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_cap = bus_if.sub ? ~bus_if.b : bus_if.b;
  assign c_cap = bus_if.sub ? 1'b1 : bus_if.cin;
`else
  assign b_cap = bus_if.b;
  assign c_cap = bus_if.cin;
`endif

  // The single full-adder cell.
  logic fa_sum, fa_cout;
  assign fa_sum  = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign fa_cout = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));

  logic last_bit;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and datapath control; every register holds unless updated.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          a_sr_d  = bus_if.a;
          b_sr_d  = b_cap;
          c_d     = c_cap;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
        c_d      = fa_cout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        if (last_bit) begin
          // Result registers update only here, so partial sums never show.
          sum_d   = {fa_sum, sum_sr_q[WIDTH-1:1]};
          carry_d = fa_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
    end
  end

  assign bus_if.busy  = (state_q != IDLE);
  assign bus_if.done  = (state_q == DONE);
  assign bus_if.sum   = sum_q;
  assign bus_if.carry = carry_q;
  assign state_o      = state_q;

endmodule
